// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scanner demo.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_scan_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN_UP  = 3'd1,
        PAUSE_HI = 3'd2,
        SCAN_DN  = 3'd3,
        PAUSE_LO = 3'd4
    } state_t;

    localparam int LED_COUNT = 8;
    localparam int POS_W     = 3;

    // Full-brightness level for a given PWM resolution.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-tick prescaler: counts 0..STEP_DIV-1 while EN, tick on the wrap cycle.
// Latency: tick is combinational from the counter state (same cycle as the wrap).
// Backpressure: EN=0 freezes the count and suppresses the tick.
module led_step_prescaler #(
    parameter int STEP_DIV = 1500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic tick
);

    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(STEP_DIV - 1));
    assign tick   = w_wrap && EN;

    // Free-running divider; holds its value whenever EN is low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (EN) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_scan_sequencer.sv
// Back-and-forth LED scanner with end dwell; optional fading trail (LED_SCAN_FADE_EN).
// Latency: STEP one CLK after the prescaler tick; LEDs one CLK after pos/levels update.
// Backpressure: EN=0 freezes prescaler, FSM and fade levels; PWM counter keeps running.
module led_scan_sequencer
    import led_scan_pkg::*;
#(
    parameter int STEP_DIV    = 1500000,
    parameter int PAUSE_STEPS = 2,
    parameter int PWM_BITS    = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5,
    output logic LED6,
    output logic LED7,
    output logic LED8,
    output logic STEP
);

    localparam int PC_W = (PAUSE_STEPS > 2) ? $clog2(PAUSE_STEPS) : 1;

    logic                 w_tick;
    state_t               r_state, w_state_nxt;
    logic [POS_W-1:0]     r_pos, w_pos_nxt;
    logic [PC_W-1:0]      r_pause_cnt, w_pause_nxt;
    logic                 r_step;
    logic [LED_COUNT-1:0] r_led, w_led_nxt;

    led_step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .tick (w_tick)
    );

    // Next-state logic: the FSM only moves on an accepted tick.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_pause_nxt = r_pause_cnt;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SCAN_UP;
                end
                SCAN_UP: begin
                    w_pos_nxt = r_pos + 1'b1;
                    if (r_pos == POS_W'(LED_COUNT - 2)) begin
                        w_state_nxt = (PAUSE_STEPS == 0) ? SCAN_DN : PAUSE_HI;
                    end
                end
                PAUSE_HI: begin
                    if (r_pause_cnt == PC_W'(PAUSE_STEPS - 1)) begin
                        w_pause_nxt = '0;
                        w_state_nxt = SCAN_DN;
                    end else begin
                        w_pause_nxt = r_pause_cnt + 1'b1;
                    end
                end
                SCAN_DN: begin
                    w_pos_nxt = r_pos - 1'b1;
                    if (r_pos == POS_W'(1)) begin
                        w_state_nxt = (PAUSE_STEPS == 0) ? SCAN_UP : PAUSE_LO;
                    end
                end
                PAUSE_LO: begin
                    if (r_pause_cnt == PC_W'(PAUSE_STEPS - 1)) begin
                        w_pause_nxt = '0;
                        w_state_nxt = SCAN_UP;
                    end else begin
                        w_pause_nxt = r_pause_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_pos_nxt   = '0;
                    w_pause_nxt = '0;
                end
            endcase
        end
    end

    // FSM state, position, dwell counter and the registered step pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_pause_cnt <= '0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_pause_cnt <= w_pause_nxt;
            r_step      <= w_tick;
        end
    end

`ifdef LED_SCAN_FADE_EN
    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(pwm_max(PWM_BITS));

    logic [PWM_BITS-1:0] r_level [LED_COUNT];
    logic [PWM_BITS-1:0] r_pwm_cnt;

    // PWM reference ramp; keeps running while frozen so the trail stays visible.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // On each step the new lit LED goes to full and every other LED halves.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                r_level[i] <= '0;
            end
        end else if (w_tick && (w_state_nxt != IDLE)) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                r_level[i] <= (w_pos_nxt == POS_W'(i)) ? LVL_MAX : (r_level[i] >> 1);
            end
        end
    end

    // Full level is solid on; otherwise the level sets the PWM duty.
    always_comb begin
        w_led_nxt = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            w_led_nxt[i] = (r_level[i] == LVL_MAX) || (r_level[i] > r_pwm_cnt);
        end
    end
`else
    // Exactly one LED at the current position, none while idle.
    always_comb begin
        w_led_nxt = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            w_led_nxt[i] = (r_state != IDLE) && (r_pos == POS_W'(i));
        end
    end
`endif

    // Registered LED drive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign LED1 = r_led[0];
    assign LED2 = r_led[1];
    assign LED3 = r_led[2];
    assign LED4 = r_led[3];
    assign LED5 = r_led[4];
    assign LED6 = r_led[5];
    assign LED7 = r_led[6];
    assign LED8 = r_led[7];
    assign STEP = r_step;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer (main instance PAUSE_STEPS=1, second instance PAUSE_STEPS=0).
// Latency: n/a.
// Backpressure: n/a.
module tb_led_scan_sequencer;

    localparam int STEP_DIV    = 4;
    localparam int PAUSE_STEPS = 1;
    localparam int PWM_BITS    = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b1;
    wire  [7:0] leds;
    wire        step;
    wire  [7:0] leds0;
    wire        step0;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int exp_scan [18] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1, 1, 2};
    int exp_np   [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 2};
    int t_tick   [19];
    int t_np     [17];

    led_scan_sequencer #(
        .STEP_DIV(STEP_DIV), .PAUSE_STEPS(PAUSE_STEPS), .PWM_BITS(PWM_BITS)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .LED1(leds[0]), .LED2(leds[1]), .LED3(leds[2]), .LED4(leds[3]),
        .LED5(leds[4]), .LED6(leds[5]), .LED7(leds[6]), .LED8(leds[7]),
        .STEP(step)
    );

    led_scan_sequencer #(
        .STEP_DIV(STEP_DIV), .PAUSE_STEPS(0), .PWM_BITS(PWM_BITS)
    ) dut_np (
        .CLK(CLK), .RST(RST), .EN(EN),
        .LED1(leds0[0]), .LED2(leds0[1]), .LED3(leds0[2]), .LED4(leds0[3]),
        .LED5(leds0[4]), .LED6(leds0[5]), .LED7(leds0[6]), .LED8(leds0[7]),
        .STEP(step0)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // The lit LED n must be on; without fading it must also be the only one.
    task automatic chk_led(input string tag, input logic [7:0] v, input int n);
`ifdef LED_SCAN_FADE_EN
        check(tag, int'(v[n-1]), 1);
`else
        check(tag, int'(v), 1 << (n - 1));
`endif
    endtask

    // Wait (bounded) for a STEP pulse; n = negedges waited, t = cycle stamp.
    task automatic wait_step(input bit which, output int n, output int t);
        n = -1;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if ((which ? step0 : step) == 1'b1) begin
                n = i + 1;
                t = cyc;
                break;
            end
        end
        if (n < 0) check("step timeout", 0, 1);
    endtask

    // Called on a negedge just after RST drops.
    task automatic start_after_release(input bit which, output int t);
        int n;
        wait_step(which, n, t);
        check("first step latency", n, 4);
        check("leds dark at first step", int'(which ? leds0 : leds), 0);
        @(negedge CLK);
        chk_led("led1 after first step", which ? leds0 : leds, 1);
        check("step is one cycle", int'(which ? step0 : step), 0);
    endtask

    initial begin
        int n, t, hi1, hi2, hi3, hi4;

        // Test 1: reset then start.
        RST = 1'b1;
        EN  = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset leds", int'(leds), 0);
        check("reset step", int'(step), 0);
        check("reset leds np", int'(leds0), 0);
        RST = 1'b0;
        start_after_release(1'b0, t_tick[1]);

        // Test 2: scan through 18 ticks.
        for (int k = 2; k <= 18; k++) begin
            wait_step(1'b0, n, t_tick[k]);
            check($sformatf("step interval %0d", k), n, 3);
            @(negedge CLK);
            chk_led($sformatf("scan tick %0d", k), leds, exp_scan[k-1]);
        end
        check("scan period", t_tick[17] - t_tick[1], 64);

        // Test 3: freeze exactly on the cycle a tick is due.
        repeat (2) @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("no step while frozen", int'(step), 0);
            chk_led("leds hold while frozen", leds, 2);
        end
        EN = 1'b1;
        @(negedge CLK);
        check("step right after EN rises", int'(step), 1);
        @(negedge CLK);
        chk_led("led3 after unfreeze", leds, 3);

        // Test 4: reset while LED5 is lit.
        for (int k = 4; k <= 5; k++) begin
            wait_step(1'b0, n, t);
            @(negedge CLK);
            chk_led($sformatf("pre-reset led%0d", k), leds, k);
        end
        RST = 1'b1;
        @(negedge CLK);
        check("mid reset leds", int'(leds), 0);
        check("mid reset step", int'(step), 0);
        RST = 1'b0;
        start_after_release(1'b0, t);
        for (int k = 2; k <= 4; k++) begin
            wait_step(1'b0, n, t);
            @(negedge CLK);
            chk_led($sformatf("restart tick %0d", k), leds, k);
        end

        // Test 6: freeze with LED4 lit and measure duty over one PWM period.
        EN  = 1'b0;
        hi1 = 0; hi2 = 0; hi3 = 0; hi4 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            hi1 += int'(leds[0]);
            hi2 += int'(leds[1]);
            hi3 += int'(leds[2]);
            hi4 += int'(leds[3]);
`ifndef LED_SCAN_FADE_EN
            check("exactly one led high", $countones(leds), 1);
`endif
        end
        EN = 1'b1;
        check("led4 high cycles", hi4, 16);
`ifdef LED_SCAN_FADE_EN
        check("led3 high cycles", hi3, 7);
        check("led2 high cycles", hi2, 3);
        check("led1 high cycles", hi1, 1);
`else
        check("led3 high cycles", hi3, 0);
        check("led1 high cycles", hi1, 0);
`endif

        // Test 5: PAUSE_STEPS=0 instance, restarted from reset.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        start_after_release(1'b1, t_np[1]);
        for (int k = 2; k <= 16; k++) begin
            wait_step(1'b1, n, t_np[k]);
            @(negedge CLK);
            chk_led($sformatf("nopause tick %0d", k), leds0, exp_np[k-1]);
        end
        check("nopause period", t_np[15] - t_np[1], 56);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
